// File: rtl/pulse_width_monitor.sv
// Run-length monitor for a toggling single-bit input: reports each completed high/low run
// and flags runs outside EXP_LEN +/- TOL. Optional stuck detector via macro PWMON_STUCK_EN.
module pulse_width_monitor #(
    parameter int CNT_W   = 8,
    parameter int EXP_LEN = 30,
    parameter int TOL     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic             run_valid,
    output logic [CNT_W-1:0] run_len,
    output logic             run_lvl,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             stuck
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   WIN_LO  = (CNT_W+1)'(EXP_LEN - TOL);
    localparam logic [CNT_W:0]   WIN_HI  = (CNT_W+1)'(EXP_LEN + TOL);

    logic             r_s1;
    logic             r_s2;
    logic             r_prev;
    logic             w_edge;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_report;
    logic             w_err;
    logic [CNT_W:0]   w_len_ext;
    logic             r_run_valid;
    logic [CNT_W-1:0] r_run_len;
    logic             r_run_lvl;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;

    // din is asynchronous: two-flop synchroniser, prev holds the last synchronised level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= din;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_edge = r_s2 ^ r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_ARM;
                ST_ARM:  w_state_nxt = w_edge ? ST_MEAS : ST_ARM;
                ST_MEAS: w_state_nxt = ST_MEAS;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Dropping en discards the in-flight run: no report, counter back to 0
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_report  = 1'b0;
        if (!en) begin
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: w_cnt_nxt = '0;
                ST_ARM:  w_cnt_nxt = w_edge ? CNT_ONE : '0;
                ST_MEAS: begin
                    if (w_edge) begin
                        w_cnt_nxt = CNT_ONE;
                        w_report  = 1'b1;
                    end else if (r_cnt == CNT_MAX) begin
                        w_cnt_nxt = CNT_MAX;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: w_cnt_nxt = '0;
            endcase
        end
    end

    assign w_len_ext = {1'b0, r_cnt};
    assign w_err     = w_report && ((w_len_ext < WIN_LO) || (w_len_ext > WIN_HI) ||
                                    (r_cnt == CNT_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_valid <= 1'b0;
            r_run_len   <= '0;
            r_run_lvl   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_run_valid <= w_report;
            r_err       <= w_err;
            if (w_report) begin
                r_run_len <= r_cnt;
                r_run_lvl <= r_prev;
            end
        end
    end

    // Counts visible err pulses; clr wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (clr) begin
            r_err_cnt <= '0;
        end else if (r_err && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + CNT_ONE;
        end
    end

`ifdef PWMON_STUCK_EN
    logic r_stuck;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stuck <= 1'b0;
        end else begin
            r_stuck <= (w_state_nxt == ST_MEAS) && (w_cnt_nxt == CNT_MAX);
        end
    end

    assign stuck = r_stuck;
`else
    assign stuck = 1'b0;
`endif

    assign run_valid = r_run_valid;
    assign run_len   = r_run_len;
    assign run_lvl   = r_run_lvl;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule
